// File: rtl/wb_lsu_sb_if.sv
// Data-memory channel of the writeback/LSU stage: posted-store drain (valid/ready)
// and a request/response read port.
interface wb_lsu_sb_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              wvalid;
  logic              wready;
  logic [ADDR_W-1:0] waddr;
  logic [XLEN-1:0]   wdata;
  logic [NB-1:0]     wstrb;
  logic              rreq;
  logic [ADDR_W-1:0] raddr;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output wvalid, waddr, wdata, wstrb, rreq, raddr,
    input  wready, rvalid, rdata
  );

  modport slave (
    input  wvalid, waddr, wdata, wstrb, rreq, raddr,
    output wready, rvalid, rdata
  );
endinterface

// File: rtl/wb_lsu_sb.sv
// Writeback/memory stage: store/load alignment and extension for XLEN 32/64, with a
// posted store buffer that must fully drain before any load is issued.
module wb_lsu_sb #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_write_i,
  input  logic                          mem_read_i,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [XLEN-1:0]               store_data_i,
  input  logic [2:0]                    funct3_i,
  input  logic [4:0]                    rd_i,
  output logic                          wb_stall_o,
  wb_lsu_sb_if.master                   dmem,
  output logic                          wb_load_valid_o,
  output logic [XLEN-1:0]               wb_load_data_o,
  output logic [4:0]                    wb_load_rd_o,
  output logic [$clog2(SB_DEPTH):0]     sb_count_o,
  output logic                          exc_o,
  output logic [1:0]                    exc_cause_o
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(SB_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  // Extract the accessed size from the lane-shifted word, then sign/zero extend.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d, input logic [2:0] f3);
    int nbits;
    logic sgn;
    logic [XLEN-1:0] r;
    nbits = ((32'd8 << f3[1:0]) > XLEN) ? XLEN : int'(32'd8 << f3[1:0]);
    sgn = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (i == nbits - 1) sgn = d[i] & ~f3[2];
    end
    for (int i = 0; i < XLEN; i++) r[i] = (i < nbits) ? d[i] : sgn;
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [XLEN-1:0]   sb_data_q [SB_DEPTH];
  logic [NB-1:0]     sb_strb_q [SB_DEPTH];
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic              lv_q, lv_d;
  logic [XLEN-1:0]   ldata_q, ldata_d;
  logic [4:0]        lrd_q, lrd_d;
  logic              exc_q, exc_d;
  logic [1:0]        cause_q, cause_d;

  logic size_legal_s, misalign_s, both_s, idle_s, bad_s, st_ok_s, ld_ok_s;
  logic full_s, push_s, pop_s, stall_s;
  logic [OB-1:0]     off_s;
  logic [NB-1:0]     strb_base_s, st_strb_s;
  logic [XLEN-1:0]   dmask_s, st_data_s, ld_shift_s;
  logic [ADDR_W-1:0] st_addr_s;

  // Request decode: size legality, alignment and acceptance conditions.
  always_comb begin
    size_legal_s = (funct3_i != 3'b111) &&
                   ((XLEN == 64) || ((funct3_i != 3'b011) && (funct3_i != 3'b110)));
    case (funct3_i[1:0])
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = addr_i[0];
      2'b10:   misalign_s = (addr_i[1:0] != 2'b00);
      default: misalign_s = (addr_i[2:0] != 3'b000);
    endcase
    both_s  = mem_write_i & mem_read_i;
    idle_s  = (state_q == S_IDLE);
    bad_s   = idle_s & (mem_write_i | mem_read_i) & (both_s | ~size_legal_s | misalign_s);
    st_ok_s = idle_s & mem_write_i & ~mem_read_i & size_legal_s & ~misalign_s;
    ld_ok_s = idle_s & mem_read_i & ~mem_write_i & size_legal_s & ~misalign_s;
    full_s  = (count_q == CNT_FULL);
    push_s  = st_ok_s & ~full_s;
    pop_s   = dmem.wvalid & dmem.wready;
  end

  // Store formatting: truncate to size, then shift data and strobes into the lane.
  always_comb begin
    off_s = addr_i[OB-1:0];
    for (int i = 0; i < NB; i++) strb_base_s[i] = (i < (1 << funct3_i[1:0]));
    for (int i = 0; i < XLEN; i++) dmask_s[i] = (i < (8 << funct3_i[1:0]));
    st_strb_s  = strb_base_s << off_s;
    st_data_s  = (store_data_i & dmask_s) << {off_s, 3'b000};
    st_addr_s  = {addr_i[ADDR_W-1:OB], {OB{1'b0}}};
    ld_shift_s = dmem.rdata >> {ld_addr_q[OB-1:0], 3'b000};
  end

  // Buffer pointers and occupancy.
  always_comb begin
    head_d = pop_s  ? head_q + PTR_ONE : head_q;
    tail_d = push_s ? tail_q + PTR_ONE : tail_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control FSM: loads wait for an empty buffer, then hold rreq until the response.
  always_comb begin
    state_d = state_q;
    stall_s = 1'b0;
    ld_addr_d = ld_addr_q;
    ld_f3_d = ld_f3_q;
    ld_rd_d = ld_rd_q;
    lv_d = 1'b0;
    ldata_d = ldata_q;
    lrd_d = lrd_q;
    exc_d = bad_s;
    if (bad_s) begin
      cause_d = (both_s | ~size_legal_s) ? 2'b11 : (mem_read_i ? 2'b01 : 2'b10);
    end else begin
      cause_d = 2'b00;
    end
    case (state_q)
      S_IDLE: begin
        if (ld_ok_s) begin
          stall_s   = 1'b1;
          ld_addr_d = addr_i;
          ld_f3_d   = funct3_i;
          ld_rd_d   = rd_i;
          state_d   = (count_q != {CW{1'b0}}) ? S_DRAIN : S_LOAD;
        end else begin
          stall_s = st_ok_s & full_s;
        end
      end
      S_DRAIN: begin
        stall_s = 1'b1;
        if (count_q == {CW{1'b0}}) state_d = S_LOAD;
        else state_d = S_DRAIN;
      end
      S_LOAD: begin
        if (dmem.rvalid) begin
          lv_d    = 1'b1;
          ldata_d = load_ext(ld_shift_s, ld_f3_q);
          lrd_d   = ld_rd_q;
          state_d = S_IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        stall_s = 1'b0;
      end
    endcase
  end

  // Control, pointer and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= {CW{1'b0}};
      head_q    <= {PW{1'b0}};
      tail_q    <= {PW{1'b0}};
      ld_addr_q <= {ADDR_W{1'b0}};
      ld_f3_q   <= 3'b000;
      ld_rd_q   <= 5'd0;
      lv_q      <= 1'b0;
      ldata_q   <= {XLEN{1'b0}};
      lrd_q     <= 5'd0;
      exc_q     <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      ld_addr_q <= ld_addr_d;
      ld_f3_q   <= ld_f3_d;
      ld_rd_q   <= ld_rd_d;
      lv_q      <= lv_d;
      ldata_q   <= ldata_d;
      lrd_q     <= lrd_d;
      exc_q     <= exc_d;
      cause_q   <= cause_d;
    end
  end

  // Buffer storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      sb_addr_q[tail_q] <= st_addr_s;
      sb_data_q[tail_q] <= st_data_s;
      sb_strb_q[tail_q] <= st_strb_s;
    end
  end

  assign dmem.wvalid     = (count_q != {CW{1'b0}});
  assign dmem.waddr      = dmem.wvalid ? sb_addr_q[head_q] : {ADDR_W{1'b0}};
  assign dmem.wdata      = dmem.wvalid ? sb_data_q[head_q] : {XLEN{1'b0}};
  assign dmem.wstrb      = dmem.wvalid ? sb_strb_q[head_q] : {NB{1'b0}};
  assign dmem.rreq       = (state_q == S_LOAD);
  assign dmem.raddr      = dmem.rreq ? {ld_addr_q[ADDR_W-1:OB], {OB{1'b0}}} : {ADDR_W{1'b0}};
  assign wb_stall_o      = stall_s;
  assign wb_load_valid_o = lv_q;
  assign wb_load_data_o  = ldata_q;
  assign wb_load_rd_o    = lrd_q;
  assign sb_count_o      = count_q;
  assign exc_o           = exc_q;
  assign exc_cause_o     = cause_q;
endmodule

// File: tb/tb_wb_lsu_sb.sv
// Scoreboard bench for wb_lsu_sb: an XLEN=32 instance checked by a drain/load/exception
// monitor, plus an XLEN=64 instance for wide stores and reset during a pending load.
module tb_wb_lsu_sb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- XLEN = 32 instance ----------------
  logic        a_rst_n = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
  logic [31:0] a_addr = 32'd0, a_sdata = 32'd0;
  logic [2:0]  a_f3 = 3'd0;
  logic [4:0]  a_rdi = 5'd0;
  logic        a_stall, a_lv, a_exc;
  logic [31:0] a_ld;
  logic [4:0]  a_lrd;
  logic [2:0]  a_cnt;
  logic [1:0]  a_cause;
  wb_lsu_sb_if #(.XLEN(32), .ADDR_W(32)) a_if ();

  wb_lsu_sb #(.XLEN(32), .ADDR_W(32), .SB_DEPTH(4)) u_a (
    .clk(clk), .reset(a_rst_n), .mem_write_i(a_wr), .mem_read_i(a_rd), .addr_i(a_addr),
    .store_data_i(a_sdata), .funct3_i(a_f3), .rd_i(a_rdi), .wb_stall_o(a_stall), .dmem(a_if.master),
    .wb_load_valid_o(a_lv), .wb_load_data_o(a_ld), .wb_load_rd_o(a_lrd), .sb_count_o(a_cnt),
    .exc_o(a_exc), .exc_cause_o(a_cause)
  );

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } st_t;
  typedef struct { logic [31:0] d; logic [4:0] rd; } ld_t;
  st_t        a_sq [$];
  ld_t        a_lq [$];
  logic [1:0] a_eq [$];
  st_t        mon_s;
  ld_t        mon_l;

  // Scoreboard monitor: every drain beat, load result and exception is popped and compared.
  always @(negedge clk) begin
    if (a_if.wvalid && a_if.wready) begin
      if (a_sq.size() == 0) check_eq("unexpected_drain", a_if.waddr, 64'hFFFF_FFFF);
      else begin
        mon_s = a_sq.pop_front();
        check_eq("drain_waddr", a_if.waddr, mon_s.a);
        check_eq("drain_wdata", a_if.wdata, mon_s.d);
        check_eq("drain_wstrb", a_if.wstrb, mon_s.s);
      end
    end
    if (a_lv) begin
      if (a_lq.size() == 0) check_eq("unexpected_load", a_ld, 64'hFFFF_FFFF);
      else begin
        mon_l = a_lq.pop_front();
        check_eq("load_data", a_ld, mon_l.d);
        check_eq("load_rd", a_lrd, mon_l.rd);
      end
    end
    if (a_exc) begin
      if (a_eq.size() == 0) check_eq("unexpected_exc", a_cause, 64'hFF);
      else check_eq("exc_cause", a_cause, a_eq.pop_front());
    end
  end

  task automatic a_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3,
                         input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es);
    int n;
    a_sq.push_back('{a: ea, d: ed, s: es});
    a_wr = 1'b1; a_addr = addr; a_sdata = data; a_f3 = f3;
    n = 0;
    @(negedge clk);
    while (a_stall && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("store_accept_timeout", (n < 50), 1'b1);
    step();
    a_wr = 1'b0;
  endtask

  task automatic a_wait_empty();
    int n;
    n = 0;
    while (a_cnt != 3'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_empty", a_cnt, 3'd0);
  endtask

  task automatic a_load_resp(input int lat, input logic [31:0] exp_raddr, input logic [31:0] rdata);
    int n;
    n = 0;
    while (!a_if.rreq && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("rreq_seen", a_if.rreq, 1'b1);
    check_eq("raddr", a_if.raddr, exp_raddr);
    check_eq("count_at_rreq", a_cnt, 3'd0);
    for (int k = 0; k < lat; k++) begin
      check_eq("rreq_held", a_if.rreq, 1'b1);
      check_eq("stall_wait_resp", a_stall, 1'b1);
      @(negedge clk);
    end
    a_if.rvalid = 1'b1;
    a_if.rdata  = rdata;
    #1;
    check_eq("stall_rvalid_cycle", a_stall, 1'b0);
    step();
    a_if.rvalid = 1'b0;
    a_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("load_valid_one_cycle", a_lv, 1'b0);
  endtask

  // ---------------- XLEN = 64 instance ----------------
  logic        b_rst_n = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
  logic [31:0] b_addr = 32'd0;
  logic [63:0] b_sdata = 64'd0;
  logic [2:0]  b_f3 = 3'd0;
  logic [4:0]  b_rdi = 5'd0;
  logic        b_stall, b_lv, b_exc;
  logic [63:0] b_ld;
  logic [4:0]  b_lrd;
  logic [2:0]  b_cnt;
  logic [1:0]  b_cause;
  wb_lsu_sb_if #(.XLEN(64), .ADDR_W(32)) b_if ();

  wb_lsu_sb #(.XLEN(64), .ADDR_W(32), .SB_DEPTH(4)) u_b (
    .clk(clk), .reset(b_rst_n), .mem_write_i(b_wr), .mem_read_i(b_rd), .addr_i(b_addr),
    .store_data_i(b_sdata), .funct3_i(b_f3), .rd_i(b_rdi), .wb_stall_o(b_stall), .dmem(b_if.master),
    .wb_load_valid_o(b_lv), .wb_load_data_o(b_ld), .wb_load_rd_o(b_lrd), .sb_count_o(b_cnt),
    .exc_o(b_exc), .exc_cause_o(b_cause)
  );

  task automatic b_store_chk(input logic [31:0] addr, input logic [63:0] data, input logic [2:0] f3,
                             input logic [31:0] ea, input logic [63:0] ed, input logic [7:0] es);
    b_wr = 1'b1; b_addr = addr; b_sdata = data; b_f3 = f3;
    @(negedge clk);
    check_eq("b_store_no_stall", b_stall, 1'b0);
    step();
    b_wr = 1'b0;
    @(negedge clk);
    check_eq("b_wvalid", b_if.wvalid, 1'b1);
    check_eq("b_waddr", b_if.waddr, ea);
    check_eq("b_wdata", b_if.wdata, ed);
    check_eq("b_wstrb", b_if.wstrb, es);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] ex_addr [4];
  logic [2:0]  ex_f3   [4];
  logic [1:0]  ex_wr   [4];
  logic [1:0]  ex_cause[4];

  initial begin
    a_if.wready = 1'b1; a_if.rvalid = 1'b0; a_if.rdata = 32'd0;
    b_if.wready = 1'b1; b_if.rvalid = 1'b0; b_if.rdata = 64'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_count", a_cnt, 3'd0);
    check_eq("rst_wvalid", a_if.wvalid, 1'b0);
    check_eq("rst_stall", a_stall, 1'b0);
    check_eq("rst_rreq", a_if.rreq, 1'b0);
    check_eq("rst_lv", a_lv, 1'b0);
    check_eq("rst_exc", {a_exc, a_cause}, 3'b000);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    step();

    // SB at a half-word offset drains as a single shifted lane.
    a_store(32'h1002, 32'h0000_00AB, 3'b000, 32'h1000, 32'h00AB_0000, 4'b0100);
    @(negedge clk);
    check_eq("sb_count_one", a_cnt, 3'd1);
    @(negedge clk);
    check_eq("sb_count_back_zero", a_cnt, 3'd0);
    step();
    a_store(32'h6002, 32'h1234_BEEF, 3'b001, 32'h6000, 32'hBEEF_0000, 4'b1100);
    a_wait_empty();
    step();

    // Fill the buffer, stall on the fifth store, then drain in order.
    a_if.wready = 1'b0;
    for (int i = 0; i < 4; i++)
      a_store(32'(4 * i), 32'hA000_0000 + 32'(i), 3'b010, 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    @(negedge clk);
    check_eq("fill_count", a_cnt, 3'd4);
    step();
    a_sq.push_back('{a: 32'h10, d: 32'hA000_0004, s: 4'hF});
    a_wr = 1'b1; a_addr = 32'h10; a_sdata = 32'hA000_0004; a_f3 = 3'b010;
    @(negedge clk);
    check_eq("full_stall", a_stall, 1'b1);
    check_eq("full_count", a_cnt, 3'd4);
    step();
    a_if.wready = 1'b1;
    @(negedge clk);
    check_eq("stall_during_pop", a_stall, 1'b1);
    step();
    @(negedge clk);
    check_eq("unstall_after_pop", a_stall, 1'b0);
    check_eq("count_after_pop", a_cnt, 3'd3);
    step();
    a_wr = 1'b0;
    @(negedge clk);
    check_eq("push_pop_same_cycle", a_cnt, 3'd3);
    a_wait_empty();

    // Load behind two buffered stores waits for the drain; LH sign-extends.
    step();
    a_if.wready = 1'b0;
    a_store(32'h5000, 32'h1111_1111, 3'b010, 32'h5000, 32'h1111_1111, 4'hF);
    a_store(32'h5004, 32'h2222_2222, 3'b010, 32'h5004, 32'h2222_2222, 4'hF);
    a_lq.push_back('{d: 32'hFFFF_8001, rd: 5'd7});
    a_rd = 1'b1; a_addr = 32'h2002; a_f3 = 3'b001; a_rdi = 5'd7;
    @(negedge clk);
    check_eq("load_stall_idle", a_stall, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("no_rreq_in_drain", a_if.rreq, 1'b0);
      check_eq("drain_stall", a_stall, 1'b1);
    end
    a_if.wready = 1'b1;
    a_load_resp(0, 32'h2000, 32'h8001_0000);

    // LBU at byte 3 with a three-cycle response delay.
    step();
    a_lq.push_back('{d: 32'h0000_009A, rd: 5'd12});
    a_rd = 1'b1; a_addr = 32'h3003; a_f3 = 3'b100; a_rdi = 5'd12;
    a_load_resp(3, 32'h3000, 32'h9A00_0000);

    // Dropped accesses: exception pulse, no memory activity, no stall.
    ex_addr[0] = 32'h4002; ex_f3[0] = 3'b010; ex_wr[0] = 2'b01; ex_cause[0] = 2'b01;
    ex_addr[1] = 32'h0008; ex_f3[1] = 3'b011; ex_wr[1] = 2'b10; ex_cause[1] = 2'b11;
    ex_addr[2] = 32'h4001; ex_f3[2] = 3'b001; ex_wr[2] = 2'b10; ex_cause[2] = 2'b10;
    ex_addr[3] = 32'h4000; ex_f3[3] = 3'b010; ex_wr[3] = 2'b11; ex_cause[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      a_eq.push_back(ex_cause[i]);
      a_wr = ex_wr[i][1]; a_rd = ex_wr[i][0]; a_addr = ex_addr[i]; a_f3 = ex_f3[i];
      @(negedge clk);
      check_eq("exc_no_stall", a_stall, 1'b0);
      step();
      a_wr = 1'b0; a_rd = 1'b0;
      @(negedge clk);
      check_eq("exc_no_rreq", a_if.rreq, 1'b0);
      check_eq("exc_no_push", a_cnt, 3'd0);
      @(negedge clk);
      check_eq("exc_one_cycle", a_exc, 1'b0);
    end
    check_eq("sq_empty", a_sq.size(), 0);
    check_eq("lq_empty", a_lq.size(), 0);
    check_eq("eq_empty", a_eq.size(), 0);

    // XLEN=64: full-width SD, then a top-lane SB.
    step();
    b_store_chk(32'h8, 64'h1122_3344_5566_7788, 3'b011, 32'h8, 64'h1122_3344_5566_7788, 8'hFF);
    b_store_chk(32'hF, 64'h0000_0000_0000_00CD, 3'b000, 32'h8, 64'hCD00_0000_0000_0000, 8'h80);

    // Reset with two stores buffered and a load pending behind them.
    b_if.wready = 1'b0;
    b_wr = 1'b1; b_addr = 32'h10; b_sdata = 64'h1; b_f3 = 3'b011;
    step();
    b_addr = 32'h18;
    step();
    b_wr = 1'b0;
    b_rd = 1'b1; b_addr = 32'h20; b_f3 = 3'b011; b_rdi = 5'd3;
    step();
    @(negedge clk);
    check_eq("b_pending_count", b_cnt, 3'd2);
    check_eq("b_pending_stall", b_stall, 1'b1);
    b_rst_n = 1'b0; b_rd = 1'b0;
    #1;
    check_eq("b_rst_count", b_cnt, 3'd0);
    check_eq("b_rst_wvalid", b_if.wvalid, 1'b0);
    check_eq("b_rst_rreq", b_if.rreq, 1'b0);
    check_eq("b_rst_stall", b_stall, 1'b0);
    @(negedge clk);
    b_rst_n = 1'b1;
    step();

    // Reset while the load is outstanding in LOAD.
    b_rd = 1'b1; b_addr = 32'h40; b_f3 = 3'b010; b_rdi = 5'd4;
    step();
    @(negedge clk);
    check_eq("b_load_rreq", b_if.rreq, 1'b1);
    check_eq("b_load_raddr", b_if.raddr, 32'h40);
    b_rst_n = 1'b0; b_rd = 1'b0;
    #1;
    check_eq("b_rst_load_rreq", b_if.rreq, 1'b0);
    @(negedge clk);
    b_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("b_no_load_pulse", b_lv, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
